// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multi-read/multi-write register file.
// Every other file of the register file slice imports this package.
package regfile_pkg;

    localparam int RF_WIDTH = 16;
    localparam int RF_DEPTH = 8;

    // A depth of 1 still needs one address bit so that port vectors stay legal.
    function automatic int rf_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef logic [rf_aw(RF_DEPTH)-1:0] rf_addr_t;

endpackage

// File: rtl/regfile_mrnw_sb_if.sv
// Decode/writeback-facing bus of the register file: write ports, read ports and scoreboard.
// The write ports carry no handshake: wr_en[p] commits on the next posedge and
// the register file always accepts it.
interface regfile_mrnw_sb_if import regfile_pkg::*; #(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = rf_aw(DEPTH);

    logic [NWR-1:0]            wr_en;
    logic [NWR-1:0][AW-1:0]    wr_addr;
    logic [NWR-1:0][WIDTH-1:0] wr_data;
    logic [NRD-1:0][AW-1:0]    rd_addr;
    logic [NRD-1:0][WIDTH-1:0] rd_data;
    logic [NRD-1:0]            rd_busy;
    logic                      sb_set_en;
    logic [AW-1:0]             sb_set_addr;
    logic [DEPTH-1:0]          busy_vec;
    logic                      wr_conflict;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr,
        input  rd_data, rd_busy, busy_vec, wr_conflict
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr,
        output rd_data, rd_busy, busy_vec, wr_conflict
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set when a producer issues, cleared when its result is written back.
// A set and a clear of the same register in one cycle leave it busy (the newer producer wins).
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int DEPTH    = RF_DEPTH,
    parameter int NWR      = 2,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = rf_aw(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NWR-1:0]         clr_en,
    input  logic [NWR-1:0][AW-1:0] clr_addr,
    input  logic                   set_en,
    input  logic [AW-1:0]          set_addr,
    output logic [DEPTH-1:0]       busy_vec
);

    logic [DEPTH-1:0] busy_next;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;

    always_comb begin
        set_vec   = '0;
        clr_vec   = '0;
        busy_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            set_vec[i] = set_en && (set_addr == AW'(i)) && !(ZERO_REG && i == 0);
            for (int p = 0; p < NWR; p++) begin
                if (clr_en[p] && clr_addr[p] == AW'(i)) begin
                    clr_vec[i] = 1'b1;
                end
            end
            busy_next[i] = (busy_vec[i] & ~clr_vec[i]) | set_vec[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_next;
        end
    end

endmodule

// File: rtl/regfile_mrnw_sb.sv
// Multi-port register file with write-port priority, optional zero register, read bypass,
// optional registered read and a busy scoreboard for decode-stage hazard detection.
module regfile_mrnw_sb import regfile_pkg::*; #(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    parameter bit REG_READ = 1'b0
) (
    input logic               clk,
    input logic               rst,
    regfile_mrnw_sb_if.slave  bus
);

    localparam int AW = rf_aw(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [NWR-1:0]            wr_ok;
    logic                      conflict_d;
    logic [DEPTH-1:0]          busy_vec;
    logic [NRD-1:0][WIDTH-1:0] rd_old;
    logic [NRD-1:0][WIDTH-1:0] rd_val;
    logic [NRD-1:0]            rd_hit;
    logic [NRD-1:0]            busy_old;

    // In range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !(ZERO_REG && a == '0);
    endfunction

    always_comb begin
        wr_ok = '0;
        for (int p = 0; p < NWR; p++) begin
            wr_ok[p] = bus.wr_en[p] && addr_ok(bus.wr_addr[p]);
        end
    end

    always_comb begin
        conflict_d = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            for (int q = p + 1; q < NWR; q++) begin
                if (wr_ok[p] && wr_ok[q] && bus.wr_addr[p] == bus.wr_addr[q]) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wr_conflict <= 1'b0;
        end else begin
            bus.wr_conflict <= conflict_d;
        end
    end

    // Ports are applied in ascending order so the highest index wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_ok[p]) begin
                    mem[bus.wr_addr[p]] <= bus.wr_data[p];
                end
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .clr_en   (wr_ok),
        .clr_addr (bus.wr_addr),
        .set_en   (bus.sb_set_en),
        .set_addr (bus.sb_set_addr),
        .busy_vec (busy_vec)
    );

    assign bus.busy_vec = busy_vec;

    // rd_old is the stored value; rd_val additionally folds in this cycle's writes.
    always_comb begin
        rd_old   = '0;
        rd_val   = '0;
        rd_hit   = '0;
        busy_old = '0;
        for (int r = 0; r < NRD; r++) begin
            if (addr_ok(bus.rd_addr[r])) begin
                rd_old[r]   = mem[bus.rd_addr[r]];
                busy_old[r] = busy_vec[bus.rd_addr[r]];
            end
            rd_val[r] = rd_old[r];
            for (int p = 0; p < NWR; p++) begin
                if (wr_ok[p] && bus.wr_addr[p] == bus.rd_addr[r]) begin
                    rd_hit[r] = 1'b1;
                    rd_val[r] = bus.wr_data[p];
                end
            end
        end
    end

    if (REG_READ) begin : g_reg_read
        logic [NRD-1:0] busy_d;

        // Registered busy tracks what busy_vec will hold when rd_data appears.
        always_comb begin
            busy_d = '0;
            for (int r = 0; r < NRD; r++) begin
                busy_d[r] = (busy_old[r] & ~rd_hit[r]) |
                            (bus.sb_set_en && bus.sb_set_addr == bus.rd_addr[r] &&
                             addr_ok(bus.rd_addr[r]));
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                bus.rd_data <= '0;
                bus.rd_busy <= '0;
            end else begin
                bus.rd_data <= rd_val;
                bus.rd_busy <= busy_d;
            end
        end
    end else begin : g_comb_read
        always_comb begin
            bus.rd_data = '0;
            bus.rd_busy = '0;
            for (int r = 0; r < NRD; r++) begin
                bus.rd_data[r] = (BYPASS && rd_hit[r]) ? rd_val[r] : rd_old[r];
                bus.rd_busy[r] = (BYPASS && rd_hit[r]) ? 1'b0 : busy_old[r];
            end
        end
    end

endmodule
